// File: rtl/hyperbus_trans_pkg.sv
// Shared types for the HyperBus transaction splitter/arbiter: FSM states,
// latched request record, row size used by optional page splitting.
package hyperbus_trans_pkg;

  localparam int PAGE_WORDS = 512;
  localparam int PAGE_BITS  = $clog2(PAGE_WORDS);

  localparam int HB_ADDR_W  = 32;
  localparam int HB_CS_W    = 2;
  localparam int HB_BURST_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } hb_state_e;

  // burst holds the words still to be issued once the request is latched
  typedef struct packed {
    logic [HB_ADDR_W-1:0]  addr;
    logic [HB_CS_W-1:0]    cs;
    logic                  write;
    logic [HB_BURST_W-1:0] burst;
    logic                  burst_type;
    logic                  addr_space;
  } trans_req_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hyperbus_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// advancing the pointer past the winner when update_i is set.
module hyperbus_rr_arb
  import hyperbus_trans_pkg::*;
#(
  parameter  int NR_CH = 2,
  localparam int CH_W  = clog2_min1(NR_CH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NR_CH-1:0] req_i,
  input  logic             update_i,
  output logic [NR_CH-1:0] gnt_o,
  output logic [CH_W-1:0]  gnt_idx_o,
  output logic             gnt_valid_o
);

  logic [CH_W-1:0] ptr_q, ptr_d;
  int              idx;

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    idx         = 0;
    for (int i = 0; i < NR_CH; i++) begin
      idx = (int'(ptr_q) + i) % NR_CH;
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_o[idx]  = 1'b1;
        gnt_idx_o   = CH_W'(idx);
      end
    end
    ptr_d = ptr_q;
    if (update_i && gnt_valid_o) ptr_d = CH_W'((int'(gnt_idx_o) + 1) % NR_CH);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/hyperbus_trans_splitter_arb.sv
// Arbitrates NR_CH request ports onto one PHY transaction port, splitting
// linear bursts into chunks of at most cfg_max_burst_i words (0 = no limit).
// Define HYPERBUS_SPLIT_PAGE_EN to also cut linear chunks at 512-word rows.
module hyperbus_trans_splitter_arb
  import hyperbus_trans_pkg::*;
#(
  parameter  int NR_CH       = 2,
  parameter  int NR_CS       = HB_CS_W,
  parameter  int BURST_WIDTH = HB_BURST_W,
  parameter  int ADDR_WIDTH  = HB_ADDR_W,
  localparam int CH_W        = clog2_min1(NR_CH)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [BURST_WIDTH-1:0]       cfg_max_burst_i,
  input  logic [NR_CH-1:0]             req_valid_i,
  output logic [NR_CH-1:0]             req_ready_o,
  input  logic [NR_CH*ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NR_CH*NR_CS-1:0]       req_cs_i,
  input  logic [NR_CH-1:0]             req_write_i,
  input  logic [NR_CH*BURST_WIDTH-1:0] req_burst_i,
  input  logic [NR_CH-1:0]             req_burst_type_i,
  input  logic [NR_CH-1:0]             req_addr_space_i,
  output logic                         trans_valid_o,
  input  logic                         trans_ready_i,
  output logic [ADDR_WIDTH-1:0]        trans_address_o,
  output logic [NR_CS-1:0]             trans_cs_o,
  output logic                         trans_write_o,
  output logic [BURST_WIDTH-1:0]       trans_burst_o,
  output logic                         trans_burst_type_o,
  output logic                         trans_address_space_o,
  input  logic                         trans_done_i,
  input  logic                         trans_error_i,
  output logic [CH_W-1:0]              owner_ch_o,
  output logic                         busy_o,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [CH_W-1:0]              rsp_ch_o,
  output logic                         rsp_error_o
);

  hb_state_e              st_q, st_d;
  trans_req_t             req_q, req_d;
  logic [BURST_WIDTH-1:0] max_q, max_d;
  logic                   err_q, err_d;
  logic [CH_W-1:0]        own_q, own_d;

  logic [NR_CH-1:0]       gnt;
  logic [CH_W-1:0]        gnt_idx;
  logic                   gnt_valid;
  logic                   arb_upd;
  logic [BURST_WIDTH-1:0] chunk;

  hyperbus_rr_arb #(.NR_CH(NR_CH)) u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_valid_i),
    .update_i    (arb_upd),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

`ifdef HYPERBUS_SPLIT_PAGE_EN
  logic [31:0] page_room;
  assign page_room = 32'(PAGE_WORDS) - 32'(req_q.addr[PAGE_BITS-1:0]);
`endif

  // Wrapped bursts always go out whole; only linear ones are cut.
  always_comb begin
    chunk = req_q.burst;
    if (req_q.burst_type) begin
      if (max_q != '0 && max_q < chunk) chunk = max_q;
`ifdef HYPERBUS_SPLIT_PAGE_EN
      if (page_room < 32'(chunk)) chunk = BURST_WIDTH'(page_room);
`endif
    end
  end

  always_comb begin
    st_d          = st_q;
    req_d         = req_q;
    max_d         = max_q;
    err_d         = err_q;
    own_d         = own_q;
    arb_upd       = 1'b0;
    req_ready_o   = '0;
    trans_valid_o = 1'b0;
    rsp_valid_o   = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          req_ready_o      = gnt;
          arb_upd          = 1'b1;
          own_d            = gnt_idx;
          max_d            = cfg_max_burst_i;
          err_d            = 1'b0;
          req_d.addr       = req_addr_i[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          req_d.cs         = req_cs_i[int'(gnt_idx)*NR_CS +: NR_CS];
          req_d.write      = req_write_i[gnt_idx];
          req_d.burst      = req_burst_i[int'(gnt_idx)*BURST_WIDTH +: BURST_WIDTH];
          req_d.burst_type = req_burst_type_i[gnt_idx];
          req_d.addr_space = req_addr_space_i[gnt_idx];
          // Zero-length requests are illegal: complete with error, no PHY work
          if (req_d.burst == '0) begin
            err_d = 1'b1;
            st_d  = ST_RESP;
          end else begin
            st_d  = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        trans_valid_o = 1'b1;
        if (trans_ready_i) st_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (trans_done_i) begin
          err_d       = err_q | trans_error_i;
          req_d.addr  = req_q.addr + HB_ADDR_W'(chunk);
          req_d.burst = req_q.burst - chunk;
          if (req_q.burst == chunk || trans_error_i) st_d = ST_RESP;
          else                                       st_d = ST_ISSUE;
        end
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
    if (rst_i) req_ready_o = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q  <= ST_IDLE;
      req_q <= '0;
      max_q <= '0;
      err_q <= 1'b0;
      own_q <= '0;
    end else begin
      st_q  <= st_d;
      req_q <= req_d;
      max_q <= max_d;
      err_q <= err_d;
      own_q <= own_d;
    end
  end

  assign trans_address_o       = req_q.addr;
  assign trans_cs_o            = req_q.cs;
  assign trans_write_o         = req_q.write;
  assign trans_burst_o         = chunk;
  assign trans_burst_type_o    = req_q.burst_type;
  assign trans_address_space_o = req_q.addr_space;
  assign owner_ch_o            = own_q;
  assign rsp_ch_o              = own_q;
  assign rsp_error_o           = err_q;
  assign busy_o                = (st_q != ST_IDLE);

endmodule

// File: tb/tb_hyperbus_trans_splitter_arb.sv
// Bench for hyperbus_trans_splitter_arb: directed and random requests checked
// against a chunk-list / round-robin reference model kept in the bench.
module tb_hyperbus_trans_splitter_arb;

  localparam int NR_CH = 2;
  localparam int NR_CS = 2;
  localparam int BW    = 12;
  localparam int AW    = 32;
  localparam int CH_W  = 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [BW-1:0]        cfg_max;
  logic [NR_CH-1:0]     req_valid, req_ready;
  logic [NR_CH*AW-1:0]  req_addr;
  logic [NR_CH*NR_CS-1:0] req_cs;
  logic [NR_CH-1:0]     req_write, req_btype, req_space;
  logic [NR_CH*BW-1:0]  req_burst;
  logic                 trans_valid, trans_ready, trans_write, trans_btype, trans_space;
  logic [AW-1:0]        trans_address;
  logic [NR_CS-1:0]     trans_cs;
  logic [BW-1:0]        trans_burst;
  logic                 trans_done, trans_error;
  logic [CH_W-1:0]      owner, rsp_ch;
  logic                 busy, rsp_valid, rsp_ready, rsp_error;

  always #5 clk = ~clk;

  hyperbus_trans_splitter_arb dut (
    .clk_i(clk), .rst_i(rst), .cfg_max_burst_i(cfg_max),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_cs_i(req_cs), .req_write_i(req_write), .req_burst_i(req_burst),
    .req_burst_type_i(req_btype), .req_addr_space_i(req_space),
    .trans_valid_o(trans_valid), .trans_ready_i(trans_ready),
    .trans_address_o(trans_address), .trans_cs_o(trans_cs),
    .trans_write_o(trans_write), .trans_burst_o(trans_burst),
    .trans_burst_type_o(trans_btype), .trans_address_space_o(trans_space),
    .trans_done_i(trans_done), .trans_error_i(trans_error),
    .owner_ch_o(owner), .busy_o(busy), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_ch_o(rsp_ch), .rsp_error_o(rsp_error)
  );

  int vectors = 0;
  int miscompares = 0;
  int ptr_m = 0;

  logic [AW-1:0]    c_addr [NR_CH];
  logic [BW-1:0]    c_burst[NR_CH];
  logic [NR_CS-1:0] c_cs   [NR_CH];
  logic             c_type [NR_CH];
  logic             c_wr   [NR_CH];
  logic             c_sp   [NR_CH];
  logic [NR_CH-1:0] vmask;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [AW-1:0] a, input int b, input logic lin,
                        input logic wr, input logic [NR_CS-1:0] cs, input logic sp);
    c_addr[ch] = a; c_burst[ch] = BW'(b); c_type[ch] = lin;
    c_wr[ch] = wr; c_cs[ch] = cs; c_sp[ch] = sp;
  endtask

  task automatic drive();
    for (int i = 0; i < NR_CH; i++) begin
      req_addr[i*AW +: AW]       = c_addr[i];
      req_burst[i*BW +: BW]      = c_burst[i];
      req_cs[i*NR_CS +: NR_CS]   = c_cs[i];
      req_write[i]               = c_wr[i];
      req_btype[i]               = c_type[i];
      req_space[i]               = c_sp[i];
    end
    req_valid = vmask;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tvalid"}, trans_valid, 0);
    check({tag, "_taddr"},  trans_address, 0);
    check({tag, "_tburst"}, trans_burst, 0);
    check({tag, "_tcs"},    trans_cs, 0);
    check({tag, "_ready"},  req_ready, 0);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_rvalid"}, rsp_valid, 0);
    check({tag, "_rerr"},   rsp_error, 0);
    check({tag, "_owner"},  owner, 0);
  endtask

  // Entered at a negedge with the DUT idle; serves exactly one grant.
  task automatic serve(input logic [BW-1:0] cfg, input int err_at);
    int g, c, rem;
    longint a;
    logic e;
    int cl[$];
    longint al[$];
    cfg_max = cfg;
    drive();
    #1;
    g = -1;
    for (int i = 0; i < NR_CH; i++)
      if (g < 0 && vmask[(ptr_m + i) % NR_CH]) g = (ptr_m + i) % NR_CH;
    if (g < 0) return;
    check("grant", req_ready, 64'(1) << g);
    ptr_m = (g + 1) % NR_CH;
    a = longint'(c_addr[g]);
    rem = int'(c_burst[g]);
    while (rem > 0) begin
      c = rem;
      if (c_type[g]) begin
        if (cfg != 0 && int'(cfg) < c) c = int'(cfg);
`ifdef HYPERBUS_SPLIT_PAGE_EN
        if (int'(512 - (a % 512)) < c) c = int'(512 - (a % 512));
`endif
      end
      al.push_back(a);
      cl.push_back(c);
      a = (a + c) % 64'h1_0000_0000;
      rem -= c;
    end
    @(negedge clk);
    vmask[g] = 1'b0;
    drive();
    check("busy_grant", busy, 1);
    check("owner", owner, g);
    e = (c_burst[g] == 0);
    for (int k = 0; k < cl.size(); k++) begin
      for (int t = 0; t < 20 && !trans_valid; t++) @(negedge clk);
      check("tvalid", trans_valid, 1);
      check("taddr", trans_address, al[k]);
      check("tburst", trans_burst, cl[k]);
      check("tcs", trans_cs, c_cs[g]);
      check("twrite", trans_write, c_wr[g]);
      check("ttype", trans_btype, c_type[g]);
      check("tspace", trans_space, c_sp[g]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      check("taddr_hold", trans_address, al[k]);
      trans_ready = 1'b1;
      @(negedge clk);
      trans_ready = 1'b0;
      check("tvalid_wait", trans_valid, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      trans_done = 1'b1;
      trans_error = (k == err_at);
      @(negedge clk);
      trans_done = 1'b0;
      trans_error = 1'b0;
      if (k == err_at) begin
        e = 1'b1;
        break;
      end
    end
    for (int t = 0; t < 20 && !rsp_valid; t++) @(negedge clk);
    check("rsp_valid", rsp_valid, 1);
    check("no_extra_trans", trans_valid, 0);
    check("rsp_ch", rsp_ch, g);
    check("rsp_err", rsp_error, e);
    // stray done while completing must not disturb the response
    trans_done = 1'b1;
    trans_error = 1'b1;
    @(negedge clk);
    trans_done = 1'b0;
    trans_error = 1'b0;
    check("rsp_hold", rsp_valid, 1);
    check("rsp_err_hold", rsp_error, e);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_done", rsp_valid, 0);
    check("idle", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cfg_max = '0;
    trans_ready = 1'b0; trans_done = 1'b0; trans_error = 1'b0; rsp_ready = 1'b0;
    vmask = '0;
    for (int i = 0; i < NR_CH; i++) set_ch(i, '0, 0, 1'b1, 1'b0, '0, 1'b0);
    drive();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // single unsplit linear burst
    set_ch(0, 32'h100, 8, 1'b1, 1'b0, 2'b01, 1'b0);
    vmask = 2'b01;
    serve(12'd0, -1);

    // cfg=4, 10 words -> 4,4,2
    set_ch(1, 32'h20, 10, 1'b1, 1'b1, 2'b10, 1'b1);
    vmask = 2'b10;
    serve(12'd4, -1);

    // both channels continuously requesting -> alternating grants
    set_ch(0, 32'h40, 2, 1'b1, 1'b0, 2'b01, 1'b0);
    set_ch(1, 32'h80, 3, 1'b1, 1'b1, 2'b10, 1'b0);
    for (int r = 0; r < 4; r++) begin
      vmask = 2'b11;
      serve(12'd0, -1);
    end

    // error on second chunk drops the rest
    set_ch(0, 32'h300, 12, 1'b1, 1'b0, 2'b01, 1'b0);
    vmask = 2'b01;
    serve(12'd4, 1);

    // zero-length request
    set_ch(1, 32'h500, 0, 1'b1, 1'b0, 2'b10, 1'b0);
    vmask = 2'b10;
    serve(12'd4, -1);

    // wrapped burst is never split
    set_ch(0, 32'h600, 16, 1'b0, 1'b1, 2'b01, 1'b0);
    vmask = 2'b01;
    serve(12'd4, -1);

    // address wrap around 2^32
    set_ch(1, 32'hFFFF_FFFE, 6, 1'b1, 1'b0, 2'b10, 1'b0);
    vmask = 2'b10;
    serve(12'd4, -1);

`ifdef HYPERBUS_SPLIT_PAGE_EN
    set_ch(0, 32'h1FE, 6, 1'b1, 1'b0, 2'b01, 1'b0);
    vmask = 2'b01;
    serve(12'd0, -1);
`endif

    // reset while waiting on the PHY
    set_ch(0, 32'h700, 8, 1'b1, 1'b0, 2'b01, 1'b0);
    vmask = 2'b01;
    drive();
    @(negedge clk);
    vmask = 2'b10;
    drive();
    for (int t = 0; t < 20 && !trans_valid; t++) @(negedge clk);
    check("rst_pre_tvalid", trans_valid, 1);
    trans_ready = 1'b1;
    @(negedge clk);
    trans_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_wait");
    vmask = '0;
    drive();
    rst = 1'b0;
    ptr_m = 0;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_rsp", rsp_valid, 0);
    end

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NR_CH; i++) begin
        logic [AW-1:0] a;
        a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                        : ($urandom & 32'h0000_0FFF);
        set_ch(i, a, $urandom_range(0, 40), 1'($urandom_range(0, 3) != 0),
               1'($urandom), NR_CS'(1 << $urandom_range(0, NR_CS - 1)), 1'($urandom));
      end
      vmask = vmask | NR_CH'($urandom_range(1, (1 << NR_CH) - 1));
      serve(BW'($urandom_range(0, 9)),
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
